// File: rtl/pc_update_sequencer.sv
// pc_update_sequencer
//
// Purpose: owns every write to the PC register. A one-cycle request from
// the main control unit (seq, jump, jr, branch, rte, or one of three
// exceptions) is turned into the PC-source mux select and the PCWrite and
// EPCWrite strobes. For exceptions, the block also runs the EPC save and
// the exception-vector fetch from memory. A one-cycle done pulse marks the
// final cycle of each request.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous, active-high reset
//   start         in   request strobe, sampled only while idle
//   req_type      in   3-bit request code (000 seq .. 111 exc_div0)
//   branch_taken  in   branch condition, sampled with start
//   PCsource      out  PC mux select (000 jump, 001 EPC, 010 ALU,
//                      011 ALU_out, 100 exception vector)
//   PCWrite       out  PC register load enable
//   EPCWrite      out  EPC register load enable
//   alu_pc_minus4 out  asks main control to drive the ALU with PC-4
//   MemRead       out  memory read strobe for the vector fetch
//   exc_addr      out  vector address (0xFD / 0xFE / 0xFF)
//   exc_cause     out  latched cause (01 opcode, 10 overflow, 11 div0)
//   busy          out  high in every state except IDLE
//   done          out  one-cycle pulse on the final cycle of a request
//
// Every output is a register loaded from the next state. This makes each
// output a pure function of the state being entered, with no
// combinational path from the inputs.

module pc_update_sequencer #(
  parameter int MEM_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] req_type,
  input  logic       branch_taken,
  output logic [2:0] PCsource,
  output logic       PCWrite,
  output logic       EPCWrite,
  output logic       alu_pc_minus4,
  output logic       MemRead,
  output logic [7:0] exc_addr,
  output logic [1:0] exc_cause,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_EXC_EPC  = 3'd2,
    ST_EXC_MEM  = 3'd3,
    ST_EXC_LOAD = 3'd4
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t     state_r;
  state_t     next_state_s;
  logic [3:0] cnt_r;
  logic [3:0] cnt_nxt_s;

  logic [2:0] pcsource_nxt_s;
  logic       pcwrite_nxt_s;
  logic       epcwrite_nxt_s;
  logic       alu_nxt_s;
  logic       memread_nxt_s;
  logic [7:0] exc_addr_nxt_s;
  logic [1:0] exc_cause_nxt_s;
  logic       busy_nxt_s;
  logic       done_nxt_s;

  // Exception codes 101/110/111 map their low two bits onto the cause.
  // The vector address is 0xFC plus that cause.
  function automatic logic is_exception(input logic [2:0] t);
    return (t[2] == 1'b1) && (t[1:0] != 2'b00);
  endfunction

  // PC mux select used during the WRITE cycle of non-exception requests.
  function automatic logic [2:0] write_source(input logic [2:0] t);
    logic [2:0] src;
    case (t)
      3'b000:  src = 3'b010;   // seq: ALU result (PC+4)
      3'b001:  src = 3'b000;   // jump target
      3'b010:  src = 3'b010;   // jr: ALU result (register value)
      3'b011:  src = 3'b011;   // branch: ALU_out holds the target
      3'b100:  src = 3'b001;   // rte: EPC
      default: src = 3'b000;
    endcase
    return src;
  endfunction

  // State and wait counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state decode together with the output values of the state being entered.
  always_comb begin
    next_state_s    = state_r;
    cnt_nxt_s       = cnt_r;
    pcsource_nxt_s  = 3'b000;
    pcwrite_nxt_s   = 1'b0;
    epcwrite_nxt_s  = 1'b0;
    alu_nxt_s       = 1'b0;
    memread_nxt_s   = 1'b0;
    done_nxt_s      = 1'b0;
    exc_addr_nxt_s  = exc_addr;
    exc_cause_nxt_s = exc_cause;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (is_exception(req_type)) begin
            next_state_s    = ST_EXC_EPC;
            exc_cause_nxt_s = req_type[1:0];
            exc_addr_nxt_s  = {6'b111111, req_type[1:0]};
            epcwrite_nxt_s  = 1'b1;
            alu_nxt_s       = 1'b1;
          end else begin
            next_state_s   = ST_WRITE;
            pcsource_nxt_s = write_source(req_type);
            done_nxt_s     = 1'b1;
            // An untaken branch still completes, but leaves PC alone.
            if ((req_type == 3'b011) && !branch_taken) begin
              pcwrite_nxt_s = 1'b0;
            end else begin
              pcwrite_nxt_s = 1'b1;
            end
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        next_state_s = ST_IDLE;
      end
      ST_EXC_EPC: begin
        next_state_s  = ST_EXC_MEM;
        cnt_nxt_s     = LAT_M1;
        memread_nxt_s = 1'b1;
      end
      ST_EXC_MEM: begin
        if (cnt_r == 4'd0) begin
          next_state_s   = ST_EXC_LOAD;
          pcwrite_nxt_s  = 1'b1;
          pcsource_nxt_s = 3'b100;
          done_nxt_s     = 1'b1;
        end else begin
          cnt_nxt_s     = cnt_r - 4'd1;
          memread_nxt_s = 1'b1;
        end
      end
      ST_EXC_LOAD: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase

    busy_nxt_s = (next_state_s != ST_IDLE);
  end

  // Output registers, loaded with the values that belong to the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PCsource      <= 3'b000;
      PCWrite       <= 1'b0;
      EPCWrite      <= 1'b0;
      alu_pc_minus4 <= 1'b0;
      MemRead       <= 1'b0;
      exc_addr      <= 8'h00;
      exc_cause     <= 2'b00;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      PCsource      <= pcsource_nxt_s;
      PCWrite       <= pcwrite_nxt_s;
      EPCWrite      <= epcwrite_nxt_s;
      alu_pc_minus4 <= alu_nxt_s;
      MemRead       <= memread_nxt_s;
      exc_addr      <= exc_addr_nxt_s;
      exc_cause     <= exc_cause_nxt_s;
      busy          <= busy_nxt_s;
      done          <= done_nxt_s;
    end
  end

endmodule

// File: doc/pc_update_sequencer.md
# pc_update_sequencer

Multicycle sequencer that owns every write to the PC register in the datapath. It takes a one-cycle request from the main control unit (sequential step, jump, jr, branch, rte, or one of three exceptions). It then drives the PC-source mux select, PCWrite and EPCWrite, and for exceptions runs the EPC save and exception-vector fetch from memory. It sits beside the main control FSM and hands back a `done` pulse when the PC update is complete.

## Interface
Parameters:
- MEM_LAT, 2, memory read latency in cycles for the vector fetch (legal range 1–15)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  request strobe from main control; sampled only in IDLE
- req_type  in  3  000 seq (PC+4), 001 jump, 010 jr, 011 branch, 100 rte, 101 exc_opcode, 110 exc_overflow, 111 exc_div0
- branch_taken  in  1  condition result, sampled with start when req_type=011
- PCsource  out  3  mux select: 000 jump target, 001 EPC, 010 ALU result, 011 ALU_out reg, 100 exception vector byte (zero-extended)
- PCWrite  out  1  PC register load enable
- EPCWrite  out  1  EPC register load enable
- alu_pc_minus4  out  1  tells main control to drive ALU with PC−4 this cycle
- MemRead  out  1  memory read strobe for the vector fetch
- exc_addr  out  8  vector address: 0xFD opcode, 0xFE overflow, 0xFF div0
- exc_cause  out  2  latched cause: 01 opcode, 10 overflow, 11 div0; 00 none
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on the final cycle of a request

## Operation
- Every output is registered and is a function of state only. Reset value: PCsource=000, exc_addr=0x00, exc_cause=00, all 1-bit outputs 0, state IDLE.
- States: IDLE, WRITE, EXC_EPC, EXC_MEM, EXC_LOAD.
- IDLE, start=1:
  - req_type 000–100 → WRITE.
  - req_type 101–111 → EXC_EPC; exc_cause and exc_addr are latched on this edge.
  - start=0 → stay in IDLE.
- WRITE (1 cycle):
  - PCWrite=1 and done=1.
  - PCsource by request: seq 010, jump 000, jr 010, branch 011, rte 001.
  - Branch with branch_taken=0: PCWrite=0, done=1, PCsource=011.
  - Next state is IDLE.
- EXC_EPC (1 cycle): EPCWrite=1, alu_pc_minus4=1, PCWrite=0. Next state is EXC_MEM, and the wait counter loads MEM_LAT−1.
- EXC_MEM: MemRead=1 and exc_addr is held. The counter decrements each cycle. At count 0 the next state is EXC_LOAD.
- EXC_LOAD (1 cycle):
  - PCWrite=1, PCsource=100, done=1, MemRead=0.
  - Next state is IDLE.
  - exc_cause stays latched until the next exception request or reset.
- start asserted while busy=1 is ignored and not queued. Main control must hold off until done.
- Undefined req_type values cannot occur, because all 8 codes are decoded.

## Timing
- start is sampled at edge N.
- Non-exception requests: WRITE occupies cycle N+1, and PC updates at edge N+2.
- Exceptions:
  - EPC_out updates at edge N+2.
  - MemRead is high for cycles N+2 … N+1+MEM_LAT.
  - EXC_LOAD occupies cycle N+2+MEM_LAT, and PC updates at the following edge.
  - Total busy length is MEM_LAT+2 cycles.
- done is high for exactly one cycle per accepted request. busy falls on the cycle after done.
- Back-to-back requests: a new start may be asserted in the cycle after done, i.e. the first IDLE cycle.
- Reset at any point, including mid-EXC_MEM, forces IDLE and reset output values immediately. No partial PCWrite or EPCWrite may be emitted after reset deasserts.
- PCWrite and EPCWrite are never high in the same cycle.

## Test plan
- Sequential step: start, req_type=000 → next cycle PCsource=010, PCWrite=1, done=1; busy is 1 for exactly 1 cycle.
- Branch: req_type=011 with taken=1 → PCWrite=1 with PCsource=011. With taken=0 → PCWrite=0 and done=1.
- Overflow exception, MEM_LAT=2: start, req_type=110 →
  - cycle 1: EPCWrite=1, alu_pc_minus4=1.
  - cycles 2–3: MemRead=1, exc_addr=0xFE.
  - cycle 4: PCWrite=1, PCsource=100, done=1.
  - exc_cause=10 afterwards.
- rte and jump: req_type=100 → PCsource=001; req_type=001 → PCsource=000; each with PCWrite=1 for 1 cycle.
- start pulsed during EXC_MEM of an opcode exception → ignored; the sequence completes unchanged with exc_addr=0xFD.
- Reset asserted in cycle 2 of an exception → all outputs at reset values at once, state IDLE, no PCWrite after release. A new seq request then completes normally.
